sdram_cmd_queue: RTL and testbench

SDRAM_CMD_QUEUE -- requirements
Module: sdram_cmd_queue

---
 rtl/sdram_cmd_queue.sv | 185 ++++++++++++++++++
 tb/tb_sdram_cmd_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_queue.sv
// sdram_cmd_queue: buffers host read/write commands in a small FIFO and feeds
// them one at a time to an SDRAM controller. Each command is sent as a single
// request pulse, then the block waits for the matching ack or a timeout, and
// finally reports a one-cycle completion to the host.
module sdram_cmd_queue #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              icmd_valid,
  output logic              ocmd_ready,
  input  logic              icmd_we,
  input  logic [ADDR_W-1:0] icmd_addr,
  input  logic [DATA_W-1:0] icmd_wdata,
  output logic              orsp_valid,
  output logic              orsp_we,
  output logic [DATA_W-1:0] orsp_rdata,
  output logic              orsp_err,
  output logic              oerr_sticky,
  output logic              owrite_req,
  output logic              oread_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [ADDR_W-1:0] oread_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  input  logic              iread_ack,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iinit_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_RESP} state_t;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              wreq_q, wreq_d, rreq_q, rreq_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
  logic              rsp_err_q, rsp_err_d, sticky_q, sticky_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              push, pop, ack_hit;
  logic [ENT_W-1:0]  head;

  // Ready depends only on the registered occupancy, never on icmd_valid.
  assign ocmd_ready = (count_q != CNT_W'(DEPTH));
  assign push       = icmd_valid && ocmd_ready;
  assign pop        = (state_q == S_IDLE) && (count_q != '0) && iinit_done;
  assign head       = mem_q[rd_ptr_q];
  assign ack_hit    = hold_we_q ? iwrite_ack : iread_ack;

  // FIFO storage: written at the tail on every accepted command.
  always_ff @(posedge iclk) begin
    if (push) mem_q[wr_ptr_q] <= {icmd_we, icmd_addr, icmd_wdata};
  end

  // FIFO pointer and occupancy update; push and pop together keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Command sequencer: pop, issue one pulse, wait for ack or timeout, respond.
  always_comb begin
    state_d     = state_q;
    hold_we_d   = hold_we_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    tmr_d       = tmr_q;
    wreq_d      = 1'b0;
    rreq_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    sticky_d    = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_we_d   = head[ENT_W-1];
          hold_addr_d = head[ADDR_W+DATA_W-1:DATA_W];
          // Read commands carry no meaningful data, so drive zeros instead.
          hold_data_d = head[ENT_W-1] ? head[DATA_W-1:0] : '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wreq_d  = hold_we_q;
        rreq_d  = !hold_we_q;
        tmr_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_hit) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = hold_we_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = hold_we_q ? '0 : iread_data;
          state_d     = S_RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = hold_we_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          sticky_d    = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops queued and in-flight commands.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      hold_we_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      tmr_q       <= '0;
      wreq_q      <= 1'b0;
      rreq_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_we_q   <= hold_we_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      tmr_q       <= tmr_d;
      wreq_q      <= wreq_d;
      rreq_q      <= rreq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      sticky_q    <= sticky_d;
    end
  end

  assign owrite_req     = wreq_q;
  assign oread_req      = rreq_q;
  assign owrite_address = hold_addr_q;
  assign oread_address  = hold_addr_q;
  assign owrite_data    = hold_data_q;
  assign orsp_valid     = rsp_valid_q;
  assign orsp_we        = rsp_we_q;
  assign orsp_err       = rsp_err_q;
  assign orsp_rdata     = rsp_rdata_q;
  assign oerr_sticky    = sticky_q;

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Scoreboard bench for sdram_cmd_queue: directed commands push expected
// requests/completions; a monitor pops and compares whenever the DUT emits one.
module tb_sdram_cmd_queue;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int TO = 16;

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct packed { logic we; logic err; logic [DW-1:0] rdata; } rsp_t;

  logic          iclk = 1'b0;
  logic          ireset_n, icmd_valid, icmd_we, iinit_done;
  logic [AW-1:0] icmd_addr;
  logic [DW-1:0] icmd_wdata, iread_data;
  logic          iwrite_ack, iread_ack;
  logic          ocmd_ready, orsp_valid, orsp_we, orsp_err, oerr_sticky;
  logic          owrite_req, oread_req;
  logic [DW-1:0] orsp_rdata, owrite_data;
  logic [AW-1:0] owrite_address, oread_address;

  sdram_cmd_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .TIMEOUT(TO)) dut (
    .iclk(iclk), .ireset_n(ireset_n), .icmd_valid(icmd_valid), .ocmd_ready(ocmd_ready),
    .icmd_we(icmd_we), .icmd_addr(icmd_addr), .icmd_wdata(icmd_wdata),
    .orsp_valid(orsp_valid), .orsp_we(orsp_we), .orsp_rdata(orsp_rdata), .orsp_err(orsp_err),
    .oerr_sticky(oerr_sticky), .owrite_req(owrite_req), .oread_req(oread_req),
    .owrite_address(owrite_address), .oread_address(oread_address), .owrite_data(owrite_data),
    .iwrite_ack(iwrite_ack), .iread_ack(iread_ack), .iread_data(iread_data),
    .iinit_done(iinit_done)
  );

  always #5 iclk = ~iclk;

  int   cyc = 0;
  int   total = 0, bad = 0;
  int   req_pulses = 0, rsp_pulses = 0;
  int   last_req_cyc = 0, last_rsp_cyc = 0, acc_cyc = 0;
  int   ack_dly = 1;
  logic no_ack = 1'b0, wrong_ack = 1'b0;
  logic [DW-1:0] rd_value = '0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every request pulse and completion against the scoreboard.
  always @(negedge iclk) begin
    req_t r;
    rsp_t s;
    logic [AW-1:0] a;
    if (owrite_req || oread_req) begin
      req_pulses++;
      last_req_cyc = cyc;
      a = owrite_req ? owrite_address : oread_address;
      $display("req cyc=%0d we=%0b addr=%h", cyc, owrite_req, a);
      total++;
      if (exp_req.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req actual=we%0b/%h required=none", owrite_req, a);
      end else begin
        r = exp_req.pop_front();
        if ((owrite_req && oread_req) || owrite_req !== r.we || a !== r.addr ||
            (r.we && owrite_data !== r.data)) begin
          bad++;
          $display("FAIL req actual=we%0b/%h/%h required=we%0b/%h/%h",
                   owrite_req, a, owrite_data, r.we, r.addr, r.data);
        end
      end
    end
    if (orsp_valid) begin
      rsp_pulses++;
      last_rsp_cyc = cyc;
      $display("rsp cyc=%0d we=%0b err=%0b rdata=%h", cyc, orsp_we, orsp_err, orsp_rdata);
      total++;
      if (exp_rsp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp actual=we%0b err%0b required=none", orsp_we, orsp_err);
      end else begin
        s = exp_rsp.pop_front();
        if (orsp_we !== s.we || orsp_err !== s.err || orsp_rdata !== s.rdata) begin
          bad++;
          $display("FAIL rsp actual=we%0b err%0b %h required=we%0b err%0b %h",
                   orsp_we, orsp_err, orsp_rdata, s.we, s.err, s.rdata);
        end
      end
    end
  end

  // Controller model: acks ack_dly cycles after each request pulse.
  initial begin
    logic w;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    iread_data = '0;
    forever begin
      @(negedge iclk);
      if ((owrite_req || oread_req) && !no_ack) begin
        w = owrite_req;
        repeat (ack_dly) @(negedge iclk);
        if (wrong_ack) w = !w;
        if (w) iwrite_ack = 1'b1;
        else begin iread_ack = 1'b1; iread_data = rd_value; end
        @(negedge iclk);
        iwrite_ack = 1'b0;
        iread_ack  = 1'b0;
        iread_data = '0;
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int b = 0;
    while (!ocmd_ready && b < 100) begin @(negedge iclk); b++; end
    if (!ocmd_ready) begin
      total++; bad++;
      $display("FAIL send_ready actual=0 required=1");
    end else begin
      icmd_valid = 1'b1; icmd_we = we; icmd_addr = a; icmd_wdata = d;
      exp_req.push_back('{we, a, d});
      @(negedge iclk);
      acc_cyc = cyc;
      icmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_req.size() != 0 || exp_rsp.size() != 0) && b < 300) begin
      @(negedge iclk); b++;
    end
    @(negedge iclk);
    if (exp_req.size() != 0 || exp_rsp.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp_req.size(), exp_rsp.size());
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, DW'(ocmd_ready), DW'(1));
    chk({tag, "_reqs"}, DW'({owrite_req, oread_req}), '0);
    chk({tag, "_rsp"}, DW'({orsp_valid, orsp_we, orsp_err, oerr_sticky}), '0);
    chk({tag, "_addr"}, DW'({owrite_address, oread_address}), '0);
    chk({tag, "_wdata"}, owrite_data, '0);
    chk({tag, "_rdata"}, orsp_rdata, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, np, nr;
    ireset_n = 1'b0; icmd_valid = 1'b0; icmd_we = 1'b0; icmd_addr = '0;
    icmd_wdata = '0; iinit_done = 1'b0;
    repeat (3) @(negedge iclk);
    chk_reset_vals("reset");
    ireset_n = 1'b1;
    iinit_done = 1'b1;
    @(negedge iclk);

    // Single write, ack one cycle after request: minimum latency.
    ack_dly = 1;
    np = req_pulses;
    exp_rsp.push_back('{1'b1, 1'b0, '0});
    send(1'b1, 22'h000001, 128'hDEADBEEFCAFEBABE123456789ABCDEF0);
    r = acc_cyc;
    drain();
    chk("w1_req_lat", DW'(last_req_cyc - r), DW'(2));
    chk("w1_rsp_lat", DW'(last_rsp_cyc - r), DW'(4));
    chk("w1_pulses", DW'(req_pulses - np), DW'(1));

    // Four writes queued while init is low: fill, drop a fifth, then release.
    iinit_done = 1'b0;
    ack_dly = 5;
    np = req_pulses;
    for (int i = 1; i <= 4; i++) begin
      exp_rsp.push_back('{1'b1, 1'b0, '0});
      send(1'b1, AW'(i), DW'(128'h1111_0000) + DW'(i));
    end
    chk("full_ready", DW'(ocmd_ready), DW'(0));
    icmd_valid = 1'b1; icmd_we = 1'b1; icmd_addr = 22'h000009; icmd_wdata = '1;
    @(negedge iclk);
    icmd_valid = 1'b0;
    repeat (3) @(negedge iclk);
    chk("full_still", DW'(ocmd_ready), DW'(0));
    chk("noinit_pulses", DW'(req_pulses - np), DW'(0));
    r = cyc;
    iinit_done = 1'b1;
    chk("rise_ready", DW'(ocmd_ready), DW'(0));
    @(negedge iclk);
    chk("pop_ready", DW'(ocmd_ready), DW'(1));
    repeat (2) @(negedge iclk);
    chk("init_req_lat", DW'(last_req_cyc - r), DW'(2));
    drain();
    chk("four_pulses", DW'(req_pulses - np), DW'(4));

    // Read with returned data.
    ack_dly = 2;
    rd_value = 128'hAAAAAAAA55555555FFFFFFFF00000000;
    exp_rsp.push_back('{1'b0, 1'b0, 128'hAAAAAAAA55555555FFFFFFFF00000000});
    send(1'b0, 22'h000003, '0);
    drain();

    // Read never acked: timeout, sticky error, next command still served.
    no_ack = 1'b1;
    exp_rsp.push_back('{1'b0, 1'b1, '0});
    send(1'b0, 22'h000005, '0);
    drain();
    chk("to_latency", DW'(last_rsp_cyc - last_req_cyc), DW'(TO));
    chk("to_sticky", DW'(oerr_sticky), DW'(1));
    no_ack = 1'b0;
    ack_dly = 1;
    exp_rsp.push_back('{1'b1, 1'b0, '0});
    send(1'b1, 22'h000006, 128'h0123);
    drain();
    chk("sticky_hold", DW'(oerr_sticky), DW'(1));

    // Read answered only with a write ack: must time out.
    wrong_ack = 1'b1;
    exp_rsp.push_back('{1'b0, 1'b1, '0});
    send(1'b0, 22'h000007, '0);
    drain();
    wrong_ack = 1'b0;

    // Stray ack while idle produces nothing.
    nr = rsp_pulses;
    iread_ack = 1'b1;
    @(negedge iclk);
    iread_ack = 1'b0;
    repeat (4) @(negedge iclk);
    chk("stray_ack", DW'(rsp_pulses - nr), DW'(0));

    // Reset in WAIT_ACK with three queued; late ack must be ignored.
    ack_dly = 8;
    np = req_pulses;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(22'h10 + i), '0);
    for (int b = 0; b < 20 && req_pulses == np; b++) @(negedge iclk);
    chk("rst_inflight", DW'(req_pulses - np), DW'(1));
    @(negedge iclk);
    exp_req.delete();
    exp_rsp.delete();
    nr = rsp_pulses;
    np = req_pulses;
    ireset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge iclk);
    ireset_n = 1'b1;
    repeat (20) @(negedge iclk);
    chk("rst_no_rsp", DW'(rsp_pulses - nr), DW'(0));
    chk("rst_no_req", DW'(req_pulses - np), DW'(0));
    chk("rst_ready", DW'(ocmd_ready), DW'(1));

    // Recovery with the top address.
    ack_dly = 1;
    exp_rsp.push_back('{1'b1, 1'b0, '0});
    send(1'b1, 22'h3FFFFF, '1);
    drain();
    chk("post_sticky", DW'(oerr_sticky), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
